// File: rtl/spi_master_param_pkg.sv
// Shared definitions for the SPI engine family (master now, slave later).
// Holds the FSM state encoding, the SPI mode encoding and the helper that
// sizes the chip-select index port.
package spi_master_param_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StShift  = 2'd2,
    StCshold = 2'd3
  } spi_state_e;

  // {cpol, cpha}
  typedef enum logic [1:0] {
    Mode0 = 2'b00,
    Mode1 = 2'b01,
    Mode2 = 2'b10,
    Mode3 = 2'b11
  } spi_mode_e;

  // Width of a chip-select index; never narrower than one bit.
  function automatic int unsigned sel_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_param_clkgen.sv
// Half-period tick generator for the SPI master.
//   clkin   : system clock
//   rst     : asynchronous reset, active-low
//   restart : forces the count back to zero (state entry)
//   div     : terminal count; one tick every div+1 cycles
//   tick    : high in the last cycle of each half-period
module spi_master_param_clkgen #(
  parameter int unsigned DIVW = 8
) (
  input  logic            clkin,
  input  logic            rst,
  input  logic            restart,
  input  logic [DIVW-1:0] div,
  output logic            tick
);

  logic [DIVW-1:0] cnt_q;

  // Equality compare: the counter never runs past div, so it never wraps.
  assign tick = (cnt_q == div);

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master with go/busy/done handshake.
//   clkin, rst          : clock, asynchronous active-low reset
//   go / busy / done    : start a word / transfer running / one-cycle completion pulse
//   cpol, cpha          : SPI mode, latched at go
//   cspol, autocs       : CS polarity; engine-driven CS or manual via cs_force
//   cs_force, cs_sel    : manual CS level, target chip select
//   hold                : keep CS asserted after this word (burst)
//   lsbfirst            : shift order, latched at go
//   div                 : SCLK half-period = div+1 clkin cycles, latched at go
//   data_i / data_o     : word to send / word received
//   miso, mosi, sclk, cs: serial pins
module spi_master_param
  import spi_master_param_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned DIVW = 8,
  parameter int unsigned NCS  = 1
) (
  input  logic                      clkin,
  input  logic                      rst,
  input  logic                      go,
  output logic                      busy,
  output logic                      done,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic                      cspol,
  input  logic                      autocs,
  input  logic                      cs_force,
  input  logic                      hold,
  input  logic                      lsbfirst,
  input  logic [DIVW-1:0]           div,
  input  logic [sel_width(NCS)-1:0] cs_sel,
  input  logic [DW-1:0]             data_i,
  output logic [DW-1:0]             data_o,
  input  logic                      miso,
  output logic                      mosi,
  output logic                      sclk,
  output logic [NCS-1:0]            cs
);

  localparam int unsigned   EcW      = $clog2(2 * DW) + 1;
  localparam logic [EcW-1:0] LastEdge = EcW'(2 * DW - 1);

  spi_state_e      state_q, state_d;
  logic [DW-1:0]   tx_q, tx_d, rx_q, rx_d, data_o_q, data_o_d;
  logic [EcW-1:0]  edge_q, edge_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            cpha_q, cpha_d, lsb_q, lsb_d, hold_q, hold_d;
  logic            mosi_q, mosi_d, sclk_q, sclk_d, done_q, done_d;
  logic [NCS-1:0]  cs_act_q, cs_act_d, cs_act, sel_onehot;
  logic [DW-1:0]   tx_next;
  logic            tick, restart, do_sample, do_shift;

  spi_master_param_clkgen #(
    .DIVW(DIVW)
  ) u_clkgen (
    .clkin  (clkin),
    .rst    (rst),
    .restart(restart),
    .div    (div_q),
    .tick   (tick)
  );

  // Divider restarts on every state change so each state starts a fresh half-period.
  assign restart = (state_d != state_q);

  assign sel_onehot = NCS'(1) << cs_sel;
  assign cs_act     = autocs ? cs_act_q : (sel_onehot & {NCS{cs_force}});
  assign cs         = ~(cs_act ^ {NCS{cspol}});

  // Even edge index = leading edge. cpha=0 samples leading, cpha=1 samples trailing.
  // With cpha=1 the first leading edge re-drives the bit already on mosi, so no shift.
  assign do_sample = ~edge_q[0] ^ cpha_q;
  assign do_shift  = ~do_sample && (edge_q != '0);
  assign tx_next   = lsb_q ? (tx_q >> 1) : (tx_q << 1);

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign data_o = data_o_q;
  assign mosi   = mosi_q;
  assign sclk   = sclk_q;

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    data_o_d = data_o_q;
    edge_d   = edge_q;
    div_d    = div_q;
    cpha_d   = cpha_q;
    lsb_d    = lsb_q;
    hold_d   = hold_q;
    mosi_d   = mosi_q;
    sclk_d   = sclk_q;
    cs_act_d = cs_act_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        sclk_d = cpol;
        if (go) begin
          state_d = StSetup;
          cpha_d  = cpha;
          lsb_d   = lsbfirst;
          div_d   = div;
          hold_d  = hold;
          tx_d    = data_i;
          rx_d    = '0;
          edge_d  = '0;
          mosi_d  = lsbfirst ? data_i[0] : data_i[DW-1];
          // Selecting a new target drops any CS held from a previous burst.
          if (autocs) cs_act_d = sel_onehot;
        end
      end
      StSetup: begin
        if (tick) state_d = StShift;
      end
      StShift: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (do_sample) rx_d = lsb_q ? {miso, rx_q[DW-1:1]} : {rx_q[DW-2:0], miso};
          if (do_shift) begin
            tx_d   = tx_next;
            mosi_d = lsb_q ? tx_next[0] : tx_next[DW-1];
          end
          if (edge_q == LastEdge) state_d = StCshold;
        end
      end
      StCshold: begin
        if (tick) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          data_o_d = rx_q;
          if (!hold_q) cs_act_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      tx_q     <= '0;
      rx_q     <= '0;
      data_o_q <= '0;
      edge_q   <= '0;
      div_q    <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      hold_q   <= 1'b0;
      mosi_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_act_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      data_o_q <= data_o_d;
      edge_q   <= edge_d;
      div_q    <= div_d;
      cpha_q   <= cpha_d;
      lsb_q    <= lsb_d;
      hold_q   <= hold_d;
      mosi_q   <= mosi_d;
      sclk_q   <= sclk_d;
      cs_act_q <= cs_act_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: an 8-bit two-CS instance and a 16-bit
// single-CS instance share clock, reset and mode controls.
module tb_spi_master_param;

  logic        clk, rst;
  logic        cpol, cpha, cspol, autocs, cs_force, hold, lsbfirst, cs_sel;
  logic [7:0]  div;
  logic        go8, busy8, done8, mosi8, sclk8, miso8, loop8, miso_tie;
  logic [7:0]  data_i8, data_o8;
  logic [1:0]  cs8;
  logic        go16, busy16, done16, mosi16, sclk16;
  logic [15:0] data_i16, data_o16;
  logic [0:0]  cs16;
  int          n_cmp, n_err;

  assign miso8 = loop8 ? mosi8 : miso_tie;

  spi_master_param #(.DW(8), .DIVW(8), .NCS(2)) u_dut8 (
    .clkin(clk), .rst(rst), .go(go8), .busy(busy8), .done(done8),
    .cpol(cpol), .cpha(cpha), .cspol(cspol), .autocs(autocs), .cs_force(cs_force),
    .hold(hold), .lsbfirst(lsbfirst), .div(div), .cs_sel(cs_sel),
    .data_i(data_i8), .data_o(data_o8), .miso(miso8), .mosi(mosi8), .sclk(sclk8), .cs(cs8)
  );

  spi_master_param #(.DW(16), .DIVW(8), .NCS(1)) u_dut16 (
    .clkin(clk), .rst(rst), .go(go16), .busy(busy16), .done(done16),
    .cpol(cpol), .cpha(cpha), .cspol(cspol), .autocs(autocs), .cs_force(cs_force),
    .hold(hold), .lsbfirst(lsbfirst), .div(div), .cs_sel(cs_sel),
    .data_i(data_i16), .data_o(data_o16), .miso(mosi16), .mosi(mosi16), .sclk(sclk16),
    .cs(cs16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one word on the 8-bit instance; call at a negedge. Cycle n=1 is the first
  // negedge after the go edge. bits collects mosi at sampling edges, first bit in MSB.
  task automatic xfer8(input logic [7:0] d, output int lat, output logic [7:0] bits,
                       output int first_samp, output logic [1:0] cs_first,
                       output logic busy_first, output logic [1:0] cs_done);
    logic prev;
    int   edges;
    int   nb;
    prev = sclk8; edges = 0; nb = 0;
    lat = -1; bits = '0; first_samp = -1; cs_first = 'x; busy_first = 1'bx; cs_done = 'x;
    data_i8 = d;
    go8 = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      go8 = 1'b0;
      if (n == 1) begin
        cs_first = cs8;
        busy_first = busy8;
      end
      if (sclk8 !== prev) begin
        edges++;
        if ((edges % 2 == 1) != (cpha == 1'b1)) begin
          if (first_samp < 0) first_samp = n;
          if (nb < 8) begin
            bits = {bits[6:0], mosi8};
            nb++;
          end
        end
      end
      prev = sclk8;
      if (done8 === 1'b1) begin
        lat = n;
        cs_done = cs8;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done8); end
    n_cmp++; if (data_o8 !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data_o8); end
    n_cmp++; if (mosi8 !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", mosi8); end
    n_cmp++; if (sclk8 !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", sclk8); end
    n_cmp++; if (cs8 !== 2'b00) begin n_err++; $display("FAIL reset_cs: got %b want 00", cs8); end
    n_cmp++; if (data_o16 !== 16'h0) begin n_err++; $display("FAIL reset_data16: got %h want 0", data_o16); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (sclk8 !== 1'b1) begin n_err++; $display("FAIL idle_sclk_cpol1: got %b want 1", sclk8); end
    cpol = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (sclk8 !== 1'b0) begin n_err++; $display("FAIL idle_sclk_cpol0: got %b want 0", sclk8); end
  endtask

  task automatic test_manual_cs;
    autocs = 1'b0; cspol = 1'b0; cs_force = 1'b1; cs_sel = 1'b1;
    #1;
    n_cmp++; if (cs8 !== 2'b01) begin n_err++; $display("FAIL manual_cs_sel1: got %b want 01", cs8); end
    cs_sel = 1'b0;
    #1;
    n_cmp++; if (cs8 !== 2'b10) begin n_err++; $display("FAIL manual_cs_sel0: got %b want 10", cs8); end
    autocs = 1'b1; cspol = 1'b1; cs_force = 1'b0;
    #1;
    n_cmp++; if (cs8 !== 2'b00) begin n_err++; $display("FAIL auto_cs_idle: got %b want 00", cs8); end
    @(negedge clk);
  endtask

  task automatic test_mode0_loop;
    int lat, fs; logic [7:0] bits; logic [1:0] csf, csd; logic bf;
    loop8 = 1'b1; cpol = 1'b0; cpha = 1'b0; hold = 1'b0; lsbfirst = 1'b0;
    xfer8(8'h5A, lat, bits, fs, csf, bf, csd);
    n_cmp++; if (lat !== 19) begin n_err++; $display("FAIL m0_latency: got %0d want 19", lat); end
    n_cmp++; if (data_o8 !== 8'h5A) begin n_err++; $display("FAIL m0_data: got %h want 5a", data_o8); end
    n_cmp++; if (bits !== 8'h5A) begin n_err++; $display("FAIL m0_mosi_bits: got %h want 5a", bits); end
    n_cmp++; if (bf !== 1'b1) begin n_err++; $display("FAIL m0_busy_next: got %b want 1", bf); end
    n_cmp++; if (csf !== 2'b01) begin n_err++; $display("FAIL m0_cs_setup: got %b want 01", csf); end
    n_cmp++; if (csd !== 2'b00) begin n_err++; $display("FAIL m0_cs_after: got %b want 00", csd); end
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL m0_busy_done: got %b want 0", busy8); end
    @(negedge clk);
    n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL m0_done_pulse: got %b want 0", done8); end
  endtask

  task automatic test_modes;
    int lat, fs; logic [7:0] bits; logic [1:0] csf, csd; logic bf;
    loop8 = 1'b0; miso_tie = 1'b1;
    for (int m = 1; m < 4; m++) begin
      cpol = m[1]; cpha = m[0];
      repeat (2) @(negedge clk);
      n_cmp++; if (sclk8 !== cpol) begin n_err++; $display("FAIL mode%0d_idle: got %b want %b", m, sclk8, cpol); end
      xfer8(8'h5A, lat, bits, fs, csf, bf, csd);
      n_cmp++; if (data_o8 !== 8'hFF) begin n_err++; $display("FAIL mode%0d_data: got %h want ff", m, data_o8); end
      n_cmp++; if (bits !== 8'h5A) begin n_err++; $display("FAIL mode%0d_bits: got %h want 5a", m, bits); end
      n_cmp++; if (fs !== (m[0] ? 4 : 3)) begin n_err++; $display("FAIL mode%0d_first_sample: got %0d want %0d", m, fs, m[0] ? 4 : 3); end
      n_cmp++; if (sclk8 !== cpol) begin n_err++; $display("FAIL mode%0d_end_sclk: got %b want %b", m, sclk8, cpol); end
    end
    cpol = 1'b0; cpha = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lsbfirst;
    int lat, fs; logic [7:0] bits; logic [1:0] csf, csd; logic bf;
    loop8 = 1'b1; lsbfirst = 1'b1;
    xfer8(8'h01, lat, bits, fs, csf, bf, csd);
    n_cmp++; if (bits !== 8'h80) begin n_err++; $display("FAIL lsb_mosi_order: got %b want 10000000", bits); end
    n_cmp++; if (data_o8 !== 8'h01) begin n_err++; $display("FAIL lsb_data: got %h want 01", data_o8); end
    lsbfirst = 1'b0;
  endtask

  task automatic test_div16;
    int lat, t1, t2; logic prev;
    lat = -1; t1 = -1; t2 = -1;
    div = 8'd3; data_i16 = 16'hA55A;
    prev = sclk16;
    go16 = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      go16 = 1'b0;
      if (sclk16 !== prev) begin
        if (t1 < 0) t1 = n; else if (t2 < 0) t2 = n;
      end
      prev = sclk16;
      if (done16 === 1'b1) begin lat = n; break; end
    end
    n_cmp++; if (t2 - t1 !== 4) begin n_err++; $display("FAIL div3_half_period: got %0d want 4", t2 - t1); end
    n_cmp++; if (lat !== 137) begin n_err++; $display("FAIL div3_latency: got %0d want 137", lat); end
    n_cmp++; if (data_o16 !== 16'hA55A) begin n_err++; $display("FAIL div3_data: got %h want a55a", data_o16); end
    div = 8'd0;
    @(negedge clk);
  endtask

  task automatic test_burst;
    int lat, fs, dones; logic [7:0] bits; logic [1:0] csf, csd; logic bf;
    loop8 = 1'b1; hold = 1'b1;
    xfer8(8'h11, lat, bits, fs, csf, bf, csd);
    n_cmp++; if (csd !== 2'b01) begin n_err++; $display("FAIL burst_w1_cs: got %b want 01", csd); end
    repeat (3) @(negedge clk);
    n_cmp++; if (cs8 !== 2'b01) begin n_err++; $display("FAIL burst_gap1_cs: got %b want 01", cs8); end
    // Word 2 with a stray go while busy.
    dones = 0; lat = -1;
    data_i8 = 8'h22;
    go8 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      go8 = (n == 5);
      if (n == 5) data_i8 = 8'hEE;
      if (done8 === 1'b1) begin
        dones++;
        if (lat < 0) lat = n;
      end
    end
    go8 = 1'b0;
    n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL busy_go_dones: got %0d want 1", dones); end
    n_cmp++; if (lat !== 19) begin n_err++; $display("FAIL busy_go_latency: got %0d want 19", lat); end
    n_cmp++; if (data_o8 !== 8'h22) begin n_err++; $display("FAIL busy_go_data: got %h want 22", data_o8); end
    n_cmp++; if (cs8 !== 2'b01) begin n_err++; $display("FAIL burst_gap2_cs: got %b want 01", cs8); end
    hold = 1'b0;
    xfer8(8'h33, lat, bits, fs, csf, bf, csd);
    n_cmp++; if (csd !== 2'b00) begin n_err++; $display("FAIL burst_w3_cs_drop: got %b want 00", csd); end
    n_cmp++; if (data_o8 !== 8'h33) begin n_err++; $display("FAIL burst_w3_data: got %h want 33", data_o8); end
  endtask

  task automatic test_reset_abort;
    int lat, fs, dones; logic [7:0] bits; logic [1:0] csf, csd; logic bf;
    loop8 = 1'b1; cpol = 1'b1; cpha = 1'b0;
    repeat (2) @(negedge clk);
    data_i8 = 8'hC3;
    go8 = 1'b1;
    @(negedge clk);
    go8 = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %b want 1", busy8); end
    rst = 1'b0;
    #1;
    n_cmp++; if (cs8 !== 2'b00) begin n_err++; $display("FAIL abort_cs: got %b want 00", cs8); end
    n_cmp++; if (sclk8 !== 1'b0) begin n_err++; $display("FAIL abort_sclk: got %b want 0", sclk8); end
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy8); end
    n_cmp++; if (data_o8 !== 8'h00) begin n_err++; $display("FAIL abort_data: got %h want 00", data_o8); end
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done8 === 1'b1) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    xfer8(8'hC3, lat, bits, fs, csf, bf, csd);
    n_cmp++; if (lat !== 19) begin n_err++; $display("FAIL abort_next_latency: got %0d want 19", lat); end
    n_cmp++; if (data_o8 !== 8'hC3) begin n_err++; $display("FAIL abort_next_data: got %h want c3", data_o8); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0;
    cpol = 1'b1; cpha = 1'b0; cspol = 1'b1; autocs = 1'b1; cs_force = 1'b0;
    hold = 1'b0; lsbfirst = 1'b0; cs_sel = 1'b0; div = 8'd0;
    go8 = 1'b0; data_i8 = '0; loop8 = 1'b1; miso_tie = 1'b0;
    go16 = 1'b0; data_i16 = '0;
    test_reset();
    test_manual_cs();
    test_mode0_loop();
    test_modes();
    test_lsbfirst();
    test_div16();
    test_burst();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
